// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Purpose:
//   Conditions raw push-button levels before they reach the speed/pause status
//   machine. Each key is handled by its own independent channel:
//     1. two-flop synchroniser that brings the asynchronous level into clk,
//     2. four-state FSM with a stable-time counter that rejects contact bounce,
//     3. registered outputs: a one-cycle press pulse and a debounced level.
//   Bit order matches the consumer: bit0 BTNU, bit1 BTND, bit2 BTNC.
//
// Parameters:
//   N_KEYS          number of independent button channels
//   DEBOUNCE_CYCLES clk cycles a synchronised level must stay stable (>= 2)
//   CNT_W           stable-counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       synchronous active-low reset
//   key_in     in   N_KEYS  raw button levels, active-high, asynchronous
//   key_press  out  N_KEYS  registered one-cycle pulse per accepted press
//   key_level  out  N_KEYS  registered debounced level (1 while held)
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_level
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // Terminal count of the stable counter. The counter starts at 0 on entry to
  // a wait state and the level is accepted on the edge that sees this value,
  // so the counter never goes beyond it and needs no wrap or saturation logic.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      // Synchroniser stages
      logic             r_s1;
      logic             r_s2;

      // Channel FSM and stable counter
      state_t           r_state;
      state_t           w_state_next;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_next;

      // Registered outputs and their next values
      logic             r_press;
      logic             r_level;
      logic             w_press_next;
      logic             w_level_next;

      // -----------------------------------------------------------------------
      // State register
      // -----------------------------------------------------------------------
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_press <= 1'b0;
          r_level <= 1'b0;
        end else begin
          r_s1    <= key_in[gi];
          r_s2    <= r_s1;
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
          r_press <= w_press_next;
          r_level <= w_level_next;
        end
      end

      // -----------------------------------------------------------------------
      // Next-state and output logic. Only the second synchroniser stage is
      // looked at; the first may still be metastable.
      // -----------------------------------------------------------------------
      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_press_next = 1'b0;

        case (r_state)
          ST_IDLE: begin
            if (r_s2) begin
              w_state_next = ST_PRESS_WAIT;
              w_cnt_next   = '0;
            end
          end

          ST_PRESS_WAIT: begin
            if (!r_s2) begin
              // Level dropped before it was stable long enough: bounce.
              w_state_next = ST_IDLE;
            end else if (r_cnt == CNT_LAST) begin
              w_state_next = ST_PRESSED;
              w_press_next = 1'b1;
            end else begin
              w_cnt_next = r_cnt + CNT_ONE;
            end
          end

          ST_PRESSED: begin
            if (!r_s2) begin
              w_state_next = ST_RELEASE_WAIT;
              w_cnt_next   = '0;
            end
          end

          ST_RELEASE_WAIT: begin
            if (r_s2) begin
              // Release glitch: return to held without a new press pulse.
              w_state_next = ST_PRESSED;
            end else if (r_cnt == CNT_LAST) begin
              w_state_next = ST_IDLE;
            end else begin
              w_cnt_next = r_cnt + CNT_ONE;
            end
          end

          default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
          end
        endcase

        // The level follows the state being entered, so it rises together
        // with the press pulse and stays up through a release glitch.
        w_level_next = (w_state_next == ST_PRESSED) ||
                       (w_state_next == ST_RELEASE_WAIT);
      end

      assign key_press[gi] = r_press;
      assign key_level[gi] = r_level;
    end
  endgenerate

endmodule
